// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - state, opcode and control-field encodings for the multicycle MIPS control FSM
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEX   = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_ORI   = 3'b010;
  localparam logic [2:0] ALUOP_ANDI  = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_imm_aluop_dec.sv
// rtl/mc_imm_aluop_dec.sv - maps an I-type opcode to the ALUOp used in IMMEX
module mc_imm_aluop_dec
  import mips_mc_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] aluop
);

  always_comb begin
    aluop = ALUOP_ADD;
    case (op)
      OP_ORI:  aluop = ALUOP_ORI;
      OP_ANDI: aluop = ALUOP_ANDI;
      OP_LUI:  aluop = ALUOP_LUI;
      default: aluop = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main Moore control FSM of the multicycle MIPS datapath
// MEM_WAIT_EN: when defined, FETCH/MEMRD/MEMWR stall on mem_ready=0.
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t     state, next_state;
  logic       illegal_q;
  logic       mem_ok;
  logic       pc_write;
  logic       branch_en;
  logic [2:0] imm_aluop;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  mc_imm_aluop_dec u_imm_aluop_dec (
    .op    (OP),
    .aluop (imm_aluop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    pc_write   = 1'b0;
    branch_en  = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = mem_ok;
        ALUSrcB  = SRCB_FOUR;
        pc_write = mem_ok;
        if (mem_ok)
          next_state = S_DECODE;
      end
      S_DECODE: begin
        // PC + (imm<<2) is parked in ALUOut in case this turns out to be a branch
        ALUSrcB = SRCB_IMMSH;
        case (OP)
          OP_LW, OP_SW:                     next_state = S_MEMADR;
          OP_RTYPE:                         next_state = S_RTYPEEX;
          OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: next_state = S_IMMEX;
          OP_J:                             next_state = S_JUMP;
          default: next_state = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ok)
          next_state = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ok)
          next_state = S_FETCH;
      end
      S_RTYPEEX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_RTYPE;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = imm_aluop;
        next_state = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        branch_en  = (OP == OP_BNE) ? ~Zero : Zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_FETCH;
    endcase

    PCEn = pc_write | branch_en;

    // Strobes are gated by reset itself so a write aborted mid-cycle never lands
    if (reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign IllegalOp = illegal_q;
  assign State     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       Zero;
  logic       mem_ready;

  logic       IorD, MemRead, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalOp;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] State;

  logic       n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_PCEn, n_ALUSrcA, n_RegDst, n_MemtoReg;
  logic       n_RegWrite, n_IllegalOp;
  logic [1:0] n_PCSrc, n_ALUSrcB;
  logic [2:0] n_ALUOp;
  logic [3:0] n_State;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp), .State(State)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .PCEn(n_PCEn),
    .PCSrc(n_PCSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp), .RegDst(n_RegDst),
    .MemtoReg(n_MemtoReg), .RegWrite(n_RegWrite), .IllegalOp(n_IllegalOp), .State(n_State)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic imm_case(input logic [5:0] op, input logic [2:0] exp_aluop);
    OP = op;
    #1;
    cyc();
    chk("imm_decode_srcb", 32'(ALUSrcB), 32'd3);
    cyc();
    chk("imm_ex_state", 32'(State), 32'd8);
    chk("imm_ex_aluop", 32'(ALUOp), 32'(exp_aluop));
    chk("imm_ex_srca", 32'(ALUSrcA), 32'd1);
    cyc();
    chk("imm_wb_state", 32'(State), 32'd9);
    chk("imm_wb_regdst", 32'(RegDst), 32'd0);
    chk("imm_wb_regwrite", 32'(RegWrite), 32'd1);
    cyc();
    chk("imm_done", 32'(State), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    int lw_st[5] = '{0, 1, 2, 3, 4};

    reset = 1'b1; OP = 6'b0; Zero = 1'b0; mem_ready = 1'b1;
    cyc();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_pcen_forced", 32'(PCEn), 32'd0);
    chk("rst_memread_forced", 32'(MemRead), 32'd0);
    chk("rst_irwrite_forced", 32'(IRWrite), 32'd0);
    cyc();
    reset = 1'b0; OP = 6'b101011;
    #1;
    chk("rst_illegal", 32'(IllegalOp), 32'd0);
    chk("fetch_pcen", 32'(PCEn), 32'd1);
    cyc(); cyc(); cyc();
    chk("sw_memwr_state", 32'(State), 32'd5);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_iord", 32'(IorD), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_memwrite_c1", 32'(MemWrite), 32'd0);
    cyc();
    chk("abort_memwrite_c2", 32'(MemWrite), 32'd0);
    reset = 1'b0; OP = 6'b100011;
    #1;
    chk("release_state", 32'(State), 32'd0);
    chk("release_illegal", 32'(IllegalOp), 32'd0);

    for (int i = 0; i < 5; i++) begin
      chk("lw_state", 32'(State), 32'(lw_st[i]));
      chk("lw_regwrite", 32'(RegWrite), 32'(i == 4));
      chk("lw_memtoreg", 32'(MemtoReg), 32'(i == 4));
      chk("lw_pcen", 32'(PCEn), 32'(i == 0));
      cyc();
    end
    chk("lw_done", 32'(State), 32'd0);

    OP = 6'b000100; Zero = 1'b1;
    #1;
    cyc(); cyc();
    chk("beq_state", 32'(State), 32'd10);
    chk("beq_pcen", 32'(PCEn), 32'd1);
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_aluop", 32'(ALUOp), 32'd1);
    cyc();
    chk("beq_done", 32'(State), 32'd0);

    OP = 6'b000101; Zero = 1'b1;
    #1;
    cyc(); cyc();
    chk("bne_state", 32'(State), 32'd10);
    chk("bne_pcen", 32'(PCEn), 32'd0);
    Zero = 1'b0;
    #1;
    chk("bne_nz_pcen", 32'(PCEn), 32'd1);
    cyc();
    chk("bne_done", 32'(State), 32'd0);

    OP = 6'b000010;
    #1;
    cyc(); cyc();
    chk("j_state", 32'(State), 32'd11);
    chk("j_pcsrc", 32'(PCSrc), 32'd2);
    chk("j_pcen", 32'(PCEn), 32'd1);
    cyc();
    chk("j_done", 32'(State), 32'd0);

    imm_case(6'b001101, 3'b010);
    imm_case(6'b001100, 3'b011);
    imm_case(6'b001111, 3'b100);
    imm_case(6'b001000, 3'b000);

    OP = 6'b000000;
    #1;
    cyc(); cyc();
    chk("r_ex_state", 32'(State), 32'd6);
    chk("r_ex_aluop", 32'(ALUOp), 32'd7);
    chk("r_ex_srcb", 32'(ALUSrcB), 32'd0);
    cyc();
    chk("r_wb_state", 32'(State), 32'd7);
    chk("r_wb_regdst", 32'(RegDst), 32'd1);
    chk("r_wb_regwrite", 32'(RegWrite), 32'd1);
    cyc();
    chk("r_done", 32'(State), 32'd0);

    OP = 6'b111111;
    #1;
    cyc();
    chk("nop_decode_pcen", 32'(n_PCEn), 32'd0);
    chk("nop_decode_regwrite", 32'(n_RegWrite), 32'd0);
    chk("nop_decode_memwrite", 32'(n_MemWrite), 32'd0);
    cyc();
    chk("nop_state", 32'(n_State), 32'd0);
    chk("nop_illegal", 32'(n_IllegalOp), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("trap_state", 32'(State), 32'd12);
      chk("trap_flag", 32'(IllegalOp), 32'd1);
      chk("trap_strobes", 32'({MemRead, MemWrite, IRWrite, PCEn, RegWrite}), 32'd0);
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("trap_cleared_state", 32'(State), 32'd0);
    chk("trap_cleared_flag", 32'(IllegalOp), 32'd0);

`ifdef MEM_WAIT_EN
    OP = 6'b100011; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_state", 32'(State), 32'd0);
      chk("wait_irwrite", 32'(IRWrite), 32'd0);
      chk("wait_pcen", 32'(PCEn), 32'd0);
      chk("wait_memread", 32'(MemRead), 32'd1);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ready_irwrite", 32'(IRWrite), 32'd1);
    chk("ready_pcen", 32'(PCEn), 32'd1);
    cyc();
    chk("ready_state", 32'(State), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
